// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath. It sequences the shared
// ALU, memory port and register file through fetch/decode/execute/memory/writeback,
// drives the datapath mux selects, stalls on mem_ready and counts retired instructions.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EX,
    S_ADDI_WB
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_retire;
  logic [31:0] r_instr_count;

  // The zero flag is consumed by the PC logic through pc_write_cond, not here.
  logic        w_unused_zero;
  assign w_unused_zero = zero;

  assign instr_count = r_instr_count;

  // State register and retired-instruction counter; the counter wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_instr_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
    end
  end

  // Next-state, control outputs and retire strobe; every output defaults to 0 so IDLE is quiet.
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_RTYPE) begin
          w_next = S_EXEC;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          w_next = S_MEM_ADDR;
        end else if (opcode == OP_BEQ) begin
          w_next = S_BRANCH;
        end else if (opcode == OP_J) begin
          w_next = S_JUMP;
        end else if (opcode == OP_ADDI) begin
          w_next = S_ADDI_EX;
        end else begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          w_next = S_MEM_RD;
        end else if (opcode == OP_SW) begin
          w_next = S_MEM_WR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM for the team's multi-cycle MIPS-subset datapath.
- Sequences the shared ALU, memory port and register file across fetch, decode, execute, memory and writeback.
- Drives the select lines of the 32-bit ALU-operand/writeback muxes and the 5-bit destination-register mux.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  1 = rd, 0 = rt (5-bit mux select)
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut (32-bit mux select)
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse on unknown opcode
- instr_count  out  32  retired-instruction counter

Behaviour:
- State encoding: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB.
- State register and instr_count are asynchronously reset by rst=1 to IDLE and 0.
- All outputs are 0 while in IDLE, and therefore during reset.
- IDLE -> FETCH unconditionally on the first clock edge after rst deasserts.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - pc_write and ir_write = mem_ready (Mealy).
  - Holds while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch-target precompute). Next state by opcode:
  - RTYPE -> EXEC
  - LW/SW -> MEM_ADDR
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDI_EX
  - any other opcode -> FETCH, with illegal=1 for that DECODE cycle only.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready=1, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
- JUMP: pc_write=1, pc_source=10. -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- Unlisted outputs are 0 in every state. mem_read and mem_write are never both 1.
- instr_count:
  - Increments by 1 on the edge that leaves MEM_WB, R_WB, ADDI_WB, BRANCH or JUMP, or leaves MEM_WR with mem_ready=1.
  - Illegal opcodes do not count.
  - Wraps from 32'hFFFFFFFF to 0.
- Latency with mem_ready tied 1: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.
- rst asserted mid-instruction: immediate return to IDLE and all outputs 0, including mid-stall. No partial write is issued after rst rises.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.

Test Plan:
- Reset: rst=1 for 3 cycles, release -> all outputs 0 in IDLE; cycle after release state is FETCH with mem_read=1, alu_src_b=01; instr_count=0.
- R-type: opcode=0, mem_ready=1 -> FETCH, DECODE, EXEC (alu_op=10), R_WB (reg_write=1, reg_dst=1); instr_count 0 -> 1 after 4 cycles.
- LW with stalls: opcode=100011, mem_ready low 2 cycles in FETCH and 3 in MEM_RD:
  - pc_write and ir_write stay 0 until the ready cycle;
  - MEM_WB asserts mem_to_reg=1, reg_write=1;
  - total 10 cycles.
- BEQ/J: BEQ with zero=1 -> pc_write_cond=1, pc_source=01 for one cycle. J -> pc_write=1, pc_source=10. Each takes 3 cycles and increments instr_count.
- Illegal opcode 6'b111111 -> illegal=1 for exactly one cycle in DECODE, next state FETCH, instr_count unchanged.
- Mid-op reset and wrap:
  - assert rst during MEM_WR stall -> mem_write drops same cycle (async);
  - force instr_count to 32'hFFFFFFFF, retire one ADDI -> instr_count=0.
